// File: rtl/card_hand_display.sv
// card_hand_display: card slot registers with seven-segment display, blink, clear sequencer and baccarat score
module card_hand_display #(
    parameter int NUM_SLOTS  = 3,
    parameter int BLINK_HALF = 25000000,
    parameter int SW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [SW-1:0]          load_slot,
    input  logic [3:0]             load_card,
    input  logic                   clear_req,
    input  logic                   blink_en,
    output logic [7*NUM_SLOTS-1:0] hex_out,
    output logic [3:0]             score,
    output logic [6:0]             score_hex,
    output logic                   slot_err
);
    localparam int CW = $clog2(BLINK_HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);
    localparam logic [SW-1:0] IDX_LAST = SW'(NUM_SLOTS - 1);

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t        state_q, state_d;
    logic [3:0]    slots_q [NUM_SLOTS];
    logic [3:0]    slots_d [NUM_SLOTS];
    logic [SW-1:0] idx_q, idx_d;
    logic [3:0]    score_q, score_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          accept, bad_slot, wrap;
    logic [6:0]    sum;

    function automatic logic [6:0] card_seg(input logic [3:0] c);
        case (c)
            4'd1:    card_seg = 7'b0001000;
            4'd2:    card_seg = 7'b0010010;
            4'd3:    card_seg = 7'b0000110;
            4'd4:    card_seg = 7'b1001100;
            4'd5:    card_seg = 7'b0100100;
            4'd6:    card_seg = 7'b0100000;
            4'd7:    card_seg = 7'b0001111;
            4'd8:    card_seg = 7'b0000000;
            4'd9:    card_seg = 7'b0000100;
            4'd10:   card_seg = 7'b0000001;
            4'd11:   card_seg = 7'b1000011;
            4'd12:   card_seg = 7'b0001100;
            4'd13:   card_seg = 7'b1001000;
            default: card_seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'b1000000;
            4'd1:    digit_seg = 7'b1111001;
            4'd2:    digit_seg = 7'b0100100;
            4'd3:    digit_seg = 7'b0110000;
            4'd4:    digit_seg = 7'b0011001;
            4'd5:    digit_seg = 7'b0010010;
            4'd6:    digit_seg = 7'b0000010;
            4'd7:    digit_seg = 7'b1111000;
            4'd8:    digit_seg = 7'b0000000;
            default: digit_seg = 7'b0010000;
        endcase
    endfunction

    assign load_ready = (state_q == IDLE) && !clear_req;
    assign accept     = load_valid && load_ready;
    assign bad_slot   = {1'b0, load_slot} >= (SW + 1)'(NUM_SLOTS);
    assign wrap       = cnt_q == CNT_LAST;
    assign score      = score_q;
    assign score_hex  = digit_seg(score_q);
    assign slot_err   = err_q;

    // Clear sequencer and write path: a clear pre-empts writes and zeroes one slot per cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slots_d = slots_q;
        err_d   = accept && bad_slot;
        if (state_q == IDLE) begin
            if (clear_req) begin
                state_d = CLEARING;
                idx_d   = '0;
            end else if (accept && !bad_slot) begin
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (load_slot == SW'(i)) slots_d[i] = load_card;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++)
                if (idx_q == SW'(i)) slots_d[i] = '0;
            if (idx_q == IDX_LAST) state_d = IDLE;
            else idx_d = idx_q + 1'b1;
        end
    end

    // Baccarat score: only codes 1-9 carry points, result is the sum modulo 10
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            sum = sum + ((slots_q[i] <= 4'd9) ? {3'b000, slots_q[i]} : 7'd0);
        score_d = 4'(sum % 7'd10);
    end

    // Blink timer: held at zero while disabled, phase flips on every counter wrap
    always_comb begin
        cnt_d   = (!blink_en || wrap) ? '0 : cnt_q + 1'b1;
        phase_d = blink_en && (phase_q ^ wrap);
    end

    // Digit images, blanked as a whole during the off phase of an enabled blink
    always_comb begin
        hex_out = '1;
        for (int i = 0; i < NUM_SLOTS; i++)
            hex_out[7*i +: 7] = (phase_q && blink_en) ? 7'h7F : card_seg(slots_q[i]);
    end

    // All state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
            score_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slots_q <= slots_d;
            score_q <= score_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end
endmodule

// File: tb/tb_card_hand_display.sv
// tb_card_hand_display: vector table with scoreboard queue plus blink, reset and clear-abort sequences
module tb_card_hand_display;
    localparam int NS = 3;
    localparam int BH = 4;
    localparam logic [20:0] BLANK = 21'h1FFFFF;

    logic        clk = 0, resetb = 0, load_valid = 0, clear_req = 0, blink_en = 0;
    logic [1:0]  load_slot = 0;
    logic [3:0]  load_card = 0;
    logic        load_ready, slot_err;
    logic [20:0] hex_out;
    logic [3:0]  score;
    logic [6:0]  score_hex;
    int          checks = 0, errors = 0;

    card_hand_display #(.NUM_SLOTS(NS), .BLINK_HALF(BH)) dut (
        .clk(clk), .resetb(resetb), .load_valid(load_valid), .load_ready(load_ready),
        .load_slot(load_slot), .load_card(load_card), .clear_req(clear_req),
        .blink_en(blink_en), .hex_out(hex_out), .score(score), .score_hex(score_hex),
        .slot_err(slot_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [1:0] s; logic [3:0] c; logic clr;
        logic rdy; logic [20:0] hex; logic [3:0] sc; logic err;
    } vec_t;
    typedef struct {logic [20:0] hex; logic [3:0] sc; logic err; int idx;} exp_t;

    vec_t tbl[15];
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] sh(input logic [3:0] d);
        logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [3:0] c, input logic clr,
                                input logic rdy, input logic [6:0] h2, input logic [6:0] h1,
                                input logic [6:0] h0, input logic [3:0] sc, input logic err);
        vec_t r;
        r.v = v; r.s = s; r.c = c; r.clr = clr; r.rdy = rdy;
        r.hex = {h2, h1, h0}; r.sc = sc; r.err = err;
        return r;
    endfunction

    task automatic post();
        exp_t e;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = q.pop_front();
        chk($sformatf("v%0d_hex", e.idx), hex_out, e.hex);
        chk($sformatf("v%0d_score", e.idx), score, e.sc);
        chk($sformatf("v%0d_score_hex", e.idx), score_hex, sh(e.sc));
        chk($sformatf("v%0d_slot_err", e.idx), slot_err, e.err);
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 1,  0, 1, 7'h7F, 7'h7F, 7'h08, 0, 0);
        tbl[1]  = mk(1, 1, 13, 0, 1, 7'h7F, 7'h48, 7'h08, 1, 0);
        tbl[2]  = mk(1, 2, 8,  0, 1, 7'h00, 7'h48, 7'h08, 1, 0);
        tbl[3]  = mk(0, 0, 0,  0, 1, 7'h00, 7'h48, 7'h08, 9, 0);
        tbl[4]  = mk(1, 0, 9,  0, 1, 7'h00, 7'h48, 7'h04, 9, 0);
        tbl[5]  = mk(1, 1, 9,  0, 1, 7'h00, 7'h04, 7'h04, 7, 0);
        tbl[6]  = mk(1, 2, 10, 0, 1, 7'h01, 7'h04, 7'h04, 6, 0);
        tbl[7]  = mk(0, 0, 0,  0, 1, 7'h01, 7'h04, 7'h04, 8, 0);
        tbl[8]  = mk(1, 3, 5,  0, 1, 7'h01, 7'h04, 7'h04, 8, 1);
        tbl[9]  = mk(0, 0, 0,  0, 1, 7'h01, 7'h04, 7'h04, 8, 0);
        tbl[10] = mk(1, 2, 7,  1, 0, 7'h01, 7'h04, 7'h04, 8, 0);
        tbl[11] = mk(1, 2, 7,  1, 0, 7'h01, 7'h04, 7'h7F, 8, 0);
        tbl[12] = mk(0, 0, 0,  0, 0, 7'h01, 7'h7F, 7'h7F, 9, 0);
        tbl[13] = mk(0, 0, 0,  0, 0, 7'h7F, 7'h7F, 7'h7F, 0, 0);
        tbl[14] = mk(0, 0, 0,  0, 1, 7'h7F, 7'h7F, 7'h7F, 0, 0);

        #1;
        chk("reset_hex", hex_out, BLANK);
        chk("reset_score", score, 0);
        chk("reset_score_hex", score_hex, 7'b1000000);
        chk("reset_slot_err", slot_err, 0);
        @(negedge clk) resetb = 1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (q.size() > 0) post();
            load_valid = tbl[i].v; load_slot = tbl[i].s; load_card = tbl[i].c; clear_req = tbl[i].clr;
            #1 chk($sformatf("v%0d_ready", i), load_ready, tbl[i].rdy);
            q.push_back('{tbl[i].hex, tbl[i].sc, tbl[i].err, i});
        end
        @(negedge clk);
        post();
        load_valid = 0; clear_req = 0;

        // blink timing with slot 0 holding an ace
        load_valid = 1; load_slot = 0; load_card = 1;
        @(negedge clk) load_valid = 0;
        blink_en = 1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("blink_k%0d", k), hex_out,
                ((k >= 4 && k <= 7) || k == 12) ? BLANK : {7'h7F, 7'h7F, 7'h08});
        end
        blink_en = 0;
        #1 chk("blink_off_now", hex_out, {7'h7F, 7'h7F, 7'h08});
        @(negedge clk) chk("blink_off_next", hex_out, {7'h7F, 7'h7F, 7'h08});

        // reset while blanked
        blink_en = 1;
        repeat (5) @(negedge clk);
        chk("midblink_blank", hex_out, BLANK);
        resetb = 0;
        #1 chk("inreset_hex", hex_out, BLANK);
        chk("inreset_score_hex", score_hex, 7'b1000000);
        @(negedge clk) resetb = 1;
        #1 chk("release_ready", load_ready, 1);
        load_valid = 1; load_slot = 0; load_card = 1;
        @(negedge clk) load_valid = 0;
        chk("after_reset_visible", hex_out, {7'h7F, 7'h7F, 7'h08});
        chk("after_reset_score_lag", score, 0);
        @(negedge clk) chk("after_reset_score", score, 1);
        blink_en = 0;

        // reset aborting a clear in progress
        clear_req = 1;
        @(negedge clk) clear_req = 0;
        #1 chk("clearing_ready", load_ready, 0);
        resetb = 0;
        #1 resetb = 1;
        #1 chk("abort_ready", load_ready, 1);
        load_valid = 1; load_slot = 1; load_card = 13;
        @(negedge clk) load_valid = 0;
        chk("abort_write", hex_out, {7'h7F, 7'h48, 7'h7F});
        repeat (3) @(negedge clk);
        chk("abort_no_residual", hex_out, {7'h7F, 7'h48, 7'h7F});
        chk("abort_score", score, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/card_hand_display.md
CARD_HAND_DISPLAY -- requirements
Module: card_hand_display

Interface
REQ-001 Parameter NUM_SLOTS, default 3: number of card slots and displayed digits, legal range 1..8.
REQ-002 Parameter BLINK_HALF, default 25000000: number of clk cycles per blink half-period, minimum 2.
REQ-003 Parameter SW = max(1, clog2(NUM_SLOTS)): width of the slot index.
REQ-004 Port clk, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-005 Port resetb, input, 1: asynchronous, active-low reset.
REQ-006 Port load_valid, input, 1: a card write request is present.
REQ-007 Port load_ready, output, 1: the block can accept a card write this cycle.
REQ-008 Port load_slot, input, SW: target slot index.
REQ-009 Port load_card, input, 4: card code (0 = empty, 1 = A, 2-10, 11 = J, 12 = Q, 13 = K).
REQ-010 Port clear_req, input, 1: pulse that starts a hand clear.
REQ-011 Port blink_en, input, 1: level that enables blinking of all digits.
REQ-012 Port hex_out, output, 7*NUM_SLOTS: active-low segments; slot i drives bits [7i+6:7i], with bit 6 = segment g and bit 0 = segment a.
REQ-013 Port score, output, 4: baccarat hand score, 0..9.
REQ-014 Port score_hex, output, 7: active-low seven-segment image of score.
REQ-015 Port slot_err, output, 1: one-cycle pulse that flags a discarded out-of-range write.

Function
REQ-016 Each slot SHALL hold a 4-bit card register.
REQ-017 Card-to-segment map, stated as code:pattern: 0:1111111, 1:0001000, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100, 10:0000001, 11:1000011, 12:0001100, 13:1001000; codes 14 and 15 map to 1111111.
REQ-018 hex_out SHALL be combinational from the slot registers and the blink phase.
REQ-019 Write handshake: a write transfers on a rising edge where load_valid and load_ready are both 1; the slot register updates on that same edge.
REQ-020 load_ready SHALL equal (state == IDLE) AND NOT clear_req.
REQ-021 An accepted write with load_slot >= NUM_SLOTS SHALL leave all slots unchanged and set slot_err to 1 for exactly the next cycle.
REQ-022 FSM states: IDLE and CLEARING.
  - IDLE -> CLEARING on clear_req = 1; the clear index is loaded with 0.
  - In CLEARING, one slot SHALL be zeroed per cycle, at index 0, 1, ... NUM_SLOTS-1.
  - After the slot NUM_SLOTS-1 write, the FSM SHALL return to IDLE; a clear therefore occupies exactly NUM_SLOTS cycles.
REQ-023 clear_req received while in CLEARING SHALL be ignored; it neither restarts nor extends the clear.
REQ-024 clear_req and load_valid asserted in the same IDLE cycle: the clear wins and the write is not accepted (load_ready = 0).
REQ-025 Card value for scoring: codes 1-9 count at face value; codes 0 and 10-15 count as 0.
REQ-026 score SHALL be registered: it equals (sum of all slot values) mod 10, one cycle after the slot registers change.
REQ-027 The score sum SHALL be at least 7 bits wide so it cannot overflow.
REQ-028 score_hex map, stated as digit:pattern: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
REQ-029 Blink counter and phase behaviour:
  - The counter counts 0..BLINK_HALF-1 and wraps to 0.
  - The blink phase toggles on each wrap.
  - When phase = 1, all hex_out bits SHALL be 1 (blank).
  - score_hex never blinks.
REQ-030 blink_en = 0 SHALL hold the counter at 0 and the phase at 0, so digits are visible.
REQ-031 After blink_en rises, the first blank SHALL begin BLINK_HALF cycles later.

Reset
REQ-032 resetb = 0 SHALL immediately and asynchronously force:
  - all slot registers to 0;
  - score to 0;
  - slot_err to 0;
  - the FSM to IDLE;
  - the blink counter and phase to 0.
REQ-033 While in reset, hex_out SHALL be all 1s and score_hex SHALL be 1000000.
REQ-034 Reset asserted mid-clear or mid-blink SHALL abort the operation with no residual effect once resetb returns high.
REQ-035 load_ready SHALL read 1 in the first cycle after reset release.

Verification (NUM_SLOTS = 3, BLINK_HALF = 4)
REQ-036 Write slot 0 = 1, slot 1 = 13, slot 2 = 8 -> hex_out = {0000000, 1001000, 0001000}; score = 9 one cycle after the last write; score_hex = 0010000.
REQ-037 Write slot 0 = 9, slot 1 = 9 -> score = 8 (18 mod 10).
REQ-038 clear_req pulse with all slots full -> load_ready = 0 for 3 cycles; slots zero in order 0, 1, 2; score = 0 one cycle after the final slot clears.
REQ-039 clear_req and load_valid in the same cycle -> no write occurs; a second clear_req during CLEARING -> clear still lasts exactly 3 cycles.
REQ-040 Write with load_slot = 3 -> slot_err pulses for 1 cycle; hex_out and score are unchanged.
REQ-041 blink_en = 1 -> hex_out is all 1s during cycles 4-7 and visible during cycles 8-11 after it rises; blink_en = 0 -> visible immediately; resetb pulse mid-blink -> visible after release.
